// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller (master) drives the strobes; the datapath (slave) drives opcode and flags.
interface multicycle_control_if;
    logic [5:0] op;
    logic       zero;
    logic       neg;
    logic       mem_ready;

    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [3:0] state;
    logic       instr_done;
    logic       err;

    modport master (
        input  op, zero, neg, mem_ready,
        output pcwrite, pcsrc, iord, memread, memwrite, irwrite, memtoreg, regdest,
               regwrite, link, alusrca, alusrcb, aluop, state, instr_done, err
    );

    modport slave (
        output op, zero, neg, mem_ready,
        input  pcwrite, pcsrc, iord, memread, memwrite, irwrite, memtoreg, regdest,
               regwrite, link, alusrca, alusrcb, aluop, state, instr_done, err
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-lite main controller: sequences each instruction over 3-5 cycles,
// with a memory-ready handshake, a wait-timeout trap and an illegal-opcode trap.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master ctrl
);

    localparam logic [5:0] OpR      = 6'd0;
    localparam logic [5:0] OpJ      = 6'd2;
    localparam logic [5:0] OpBeq    = 6'd4;
    localparam logic [5:0] OpOri    = 6'd13;
    localparam logic [5:0] OpBltzal = 6'd34;
    localparam logic [5:0] OpLw     = 6'd35;
    localparam logic [5:0] OpSw     = 6'd43;

    localparam logic [CNT_W-1:0] CntLimit = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StOriEx  = 4'd10,
        StOriWb  = 4'd11,
        StTrap   = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       wait_st;
    logic       timeout_hit;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdest;
    logic       regwrite;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is zero outside the wait states, so entry into one always starts from zero.
    always_comb begin
        wait_st     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
        timeout_hit = (TIMEOUT != 0) && wait_st && !ctrl.mem_ready && (cnt_q == CntLimit);
        cnt_d       = '0;
        if (wait_st && !ctrl.mem_ready) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        memtoreg   = 1'b0;
        regdest    = 1'b0;
        regwrite   = 1'b0;
        link       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        err        = 1'b0;

        case (state_q)
            StFetch: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = ctrl.mem_ready;
                irwrite = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (ctrl.op)
                    OpR:             state_d = StExec;
                    OpLw, OpSw:      state_d = StMemAdr;
                    OpBeq, OpBltzal: state_d = StBranch;
                    OpOri:           state_d = StOriEx;
                    OpJ:             state_d = StJump;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (ctrl.op == OpLw) begin
                    state_d = StMemRd;
                end else if (ctrl.op == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StTrap;
                end
            end
            StMemRd: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (ctrl.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = ctrl.mem_ready;
                if (ctrl.mem_ready) state_d = StFetch;
            end
            StExec: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = StRwb;
            end
            StRwb: begin
                regdest    = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                state_d    = StFetch;
                // bltzal links unconditionally; PC already holds PC+4.
                if (ctrl.op == OpBltzal) begin
                    pcwrite  = ctrl.neg;
                    regwrite = 1'b1;
                    link     = 1'b1;
                end else begin
                    pcwrite = ctrl.zero;
                end
            end
            StOriEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                state_d = StOriWb;
            end
            StOriWb: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pcwrite    = 1'b1;
                pcsrc      = 2'b10;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                err     = 1'b1;
                state_d = StTrap;
            end
            default: state_d = StTrap;
        endcase

        if (timeout_hit) state_d = StTrap;
    end

    // Mealy strobes are gated by reset so no PC/IR load or completion leaks out during reset.
    assign ctrl.pcwrite    = pcwrite & rst_n;
    assign ctrl.irwrite    = irwrite & rst_n;
    assign ctrl.instr_done = instr_done & rst_n;
    assign ctrl.pcsrc      = pcsrc;
    assign ctrl.iord       = iord;
    assign ctrl.memread    = memread;
    assign ctrl.memwrite   = memwrite;
    assign ctrl.memtoreg   = memtoreg;
    assign ctrl.regdest    = regdest;
    assign ctrl.regwrite   = regwrite;
    assign ctrl.link       = link;
    assign ctrl.alusrca    = alusrca;
    assign ctrl.alusrcb    = alusrcb;
    assign ctrl.aluop      = aluop;
    assign ctrl.state      = state_q;
    assign ctrl.err        = err;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases plus random instruction streams
// checked against an instruction-level model of state traces and strobe counts.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    multicycle_control_if bus ();

    multicycle_control #(
        .TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Builds the expected state trace for one instruction, drives it and checks strobe totals.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                             input logic z, input logic n);
        int st[$];
        bit rdy[$];
        int c_rw = 0, c_mw = 0, c_mr = 0, c_pcw = 0, c_link = 0, c_irw = 0, c_m2r = 0;
        int e_rw, e_mw, e_mr, e_pcw, e_link, e_m2r;
        int last;

        for (int i = 0; i < wf; i++) begin st.push_back(0); rdy.push_back(1'b0); end
        st.push_back(0); rdy.push_back(1'b1);
        st.push_back(1); rdy.push_back(1'($urandom));
        case (op)
            6'd0: begin
                st.push_back(6); rdy.push_back(1'($urandom));
                st.push_back(7); rdy.push_back(1'($urandom));
            end
            6'd35: begin
                st.push_back(2); rdy.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st.push_back(3); rdy.push_back(1'b0); end
                st.push_back(3); rdy.push_back(1'b1);
                st.push_back(4); rdy.push_back(1'($urandom));
            end
            6'd43: begin
                st.push_back(2); rdy.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st.push_back(5); rdy.push_back(1'b0); end
                st.push_back(5); rdy.push_back(1'b1);
            end
            6'd13: begin
                st.push_back(10); rdy.push_back(1'($urandom));
                st.push_back(11); rdy.push_back(1'($urandom));
            end
            6'd2:    begin st.push_back(9); rdy.push_back(1'($urandom)); end
            default: begin st.push_back(8); rdy.push_back(1'($urandom)); end
        endcase

        e_rw   = (op == 0 || op == 35 || op == 13 || op == 34) ? 1 : 0;
        e_mw   = (op == 43) ? wm + 1 : 0;
        e_mr   = wf + 1 + ((op == 35) ? wm + 1 : 0);
        e_pcw  = 1 + ((op == 4 && z) ? 1 : 0) + ((op == 34 && n) ? 1 : 0) + ((op == 2) ? 1 : 0);
        e_link = (op == 34) ? 1 : 0;
        e_m2r  = (op == 35) ? 1 : 0;
        last   = st.size() - 1;

        for (int k = 0; k <= last; k++) begin
            bus.op        = op;
            bus.zero      = z;
            bus.neg       = n;
            bus.mem_ready = rdy[k];
            #1;
            chk($sformatf("state op%0d cyc%0d", op, k), {28'd0, bus.state}, st[k]);
            chk($sformatf("instr_done op%0d cyc%0d", op, k), {31'd0, bus.instr_done},
                (k == last) ? 1 : 0);
            if (st[k] == 10) begin
                chk("oriex aluop", {30'd0, bus.aluop}, 3);
                chk("oriex alusrcb", {30'd0, bus.alusrcb}, 2);
            end
            if (st[k] == 11) chk("oriwb regdest", {31'd0, bus.regdest}, 0);
            if (st[k] == 5) chk("memwr iord", {31'd0, bus.iord}, 1);
            if (st[k] == 8) chk("branch pcsrc", {30'd0, bus.pcsrc}, 1);
            c_rw   += int'(bus.regwrite);
            c_mw   += int'(bus.memwrite);
            c_mr   += int'(bus.memread);
            c_pcw  += int'(bus.pcwrite);
            c_link += int'(bus.link);
            c_irw  += int'(bus.irwrite);
            c_m2r  += int'(bus.memtoreg);
            @(negedge clk);
        end

        chk($sformatf("regwrite count op%0d", op), c_rw, e_rw);
        chk($sformatf("memwrite count op%0d", op), c_mw, e_mw);
        chk($sformatf("memread count op%0d", op), c_mr, e_mr);
        chk($sformatf("pcwrite count op%0d z%0d n%0d", op, z, n), c_pcw, e_pcw);
        chk($sformatf("link count op%0d", op), c_link, e_link);
        chk($sformatf("irwrite count op%0d", op), c_irw, 1);
        chk($sformatf("memtoreg count op%0d", op), c_m2r, e_m2r);
        chk("err after instr", {31'd0, bus.err}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset state", {28'd0, bus.state}, 0);
        chk("reset err", {31'd0, bus.err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] ops[7];
        ops = '{6'd0, 6'd2, 6'd4, 6'd13, 6'd34, 6'd35, 6'd43};

        rst_n         = 1'b0;
        bus.op        = 6'd0;
        bus.zero      = 1'b0;
        bus.neg       = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        chk("rst state", {28'd0, bus.state}, 0);
        chk("rst pcwrite", {31'd0, bus.pcwrite}, 0);
        chk("rst irwrite", {31'd0, bus.irwrite}, 0);
        chk("rst instr_done", {31'd0, bus.instr_done}, 0);
        chk("rst memread", {31'd0, bus.memread}, 1);
        chk("rst alusrcb", {30'd0, bus.alusrcb}, 1);
        chk("rst regwrite", {31'd0, bus.regwrite}, 0);
        chk("rst err", {31'd0, bus.err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'd35, 0, 0, 1'b0, 1'b0);
        run_instr(6'd43, 0, 3, 1'b0, 1'b0);
        run_instr(6'd4, 0, 0, 1'b0, 1'b0);
        run_instr(6'd4, 0, 0, 1'b1, 1'b0);
        run_instr(6'd34, 0, 0, 1'b0, 1'b1);
        run_instr(6'd34, 0, 0, 1'b0, 1'b0);
        run_instr(6'd13, 0, 0, 1'b0, 1'b0);
        run_instr(6'd2, 0, 0, 1'b0, 1'b0);
        run_instr(6'd0, 2, 0, 1'b0, 1'b0);

        repeat (40) begin
            run_instr(ops[$urandom_range(0, 6)], int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end

        // 15 consecutive not-ready cycles in FETCH trap.
        for (int i = 0; i < 15; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            chk($sformatf("timeout wait cyc%0d", i), {28'd0, bus.state}, 0);
            @(negedge clk);
        end
        #1;
        chk("timeout state", {28'd0, bus.state}, 12);
        chk("timeout err", {31'd0, bus.err}, 1);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            @(negedge clk);
            #1;
            chk("trap hold state", {28'd0, bus.state}, 12);
            chk("trap hold err", {31'd0, bus.err}, 1);
            chk("trap pcwrite", {31'd0, bus.pcwrite}, 0);
            chk("trap memread", {31'd0, bus.memread}, 0);
        end
        do_reset();

        bus.op        = 6'd63;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("illegal decode", {28'd0, bus.state}, 1);
        @(negedge clk);
        #1;
        chk("illegal trap", {28'd0, bus.state}, 12);
        chk("illegal err", {31'd0, bus.err}, 1);
        do_reset();

        bus.op = 6'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("exec reached", {28'd0, bus.state}, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst state", {28'd0, bus.state}, 0);
        chk("async rst pcwrite", {31'd0, bus.pcwrite}, 0);
        chk("async rst regwrite", {31'd0, bus.regwrite}, 0);
        chk("async rst memwrite", {31'd0, bus.memwrite}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'd13, 1, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
